// File: rtl/call_return_stack_if.sv
// Call/return stack bus: control-unit side (master) and stack side (slave).
interface call_return_stack_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned PTR_W  = 5
);
  logic              PUSH;
  logic              POP;
  logic [ADDR_W-1:0] PUSH_DATA;
  logic              FLUSH;
  logic [ADDR_W-1:0] STACK_OUT;
  logic [PTR_W:0]    COUNT;
  logic              EMPTY;
  logic              FULL;
  logic              OVF;
  logic              UNF;

  modport master (
    output PUSH, POP, PUSH_DATA, FLUSH,
    input  STACK_OUT, COUNT, EMPTY, FULL, OVF, UNF
  );

  modport slave (
    input  PUSH, POP, PUSH_DATA, FLUSH,
    output STACK_OUT, COUNT, EMPTY, FULL, OVF, UNF
  );
endinterface

// File: rtl/call_return_stack.sv
// Hardware return-address stack feeding the PC FROM_STACK input.
// Grows downward; the top entry is read combinationally so RET has zero latency.
module call_return_stack #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned PTR_W  = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  call_return_stack_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << PTR_W;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              unf;
  logic              empty_c;
  logic              full_c;

  // Occupancy flags derived from the entry count.
  always_comb begin
    empty_c = (count == CNT_W'(0));
    full_c  = (count == CNT_W'(DEPTH));
  end

  // Pointer, count, sticky error flags and RAM write; reset leaves RAM contents alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sp    <= PTR_W'(0);
      count <= CNT_W'(0);
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (bus.FLUSH) begin
      sp    <= PTR_W'(0);
      count <= CNT_W'(0);
    end else begin
      case ({bus.PUSH, bus.POP})
        2'b10: begin
          if (full_c) begin
            ovf <= 1'b1;
          end else begin
            mem[sp - PTR_W'(1)] <= bus.PUSH_DATA;
            sp                  <= sp - PTR_W'(1);
            count               <= count + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty_c) begin
            unf <= 1'b1;
          end else begin
            sp    <= sp + PTR_W'(1);
            count <= count - CNT_W'(1);
          end
        end
        2'b11: begin
          if (empty_c) begin
            // Nothing to replace: acts as a plain push but records the bad pop.
            mem[sp - PTR_W'(1)] <= bus.PUSH_DATA;
            sp                  <= sp - PTR_W'(1);
            count               <= count + CNT_W'(1);
            unf                 <= 1'b1;
          end else begin
            mem[sp] <= bus.PUSH_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: top of stack is a pure asynchronous read.
  assign bus.STACK_OUT = mem[sp];
  assign bus.COUNT     = count;
  assign bus.EMPTY     = empty_c;
  assign bus.FULL      = full_c;
  assign bus.OVF       = ovf;
  assign bus.UNF       = unf;
endmodule

// File: tb/tb_call_return_stack.sv
// Self-checking bench for call_return_stack using a LIFO model and a pop scoreboard.
module tb_call_return_stack;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PTR_W  = 5;
  localparam int unsigned DEPTH  = 32;

  logic clk;
  logic rst;

  call_return_stack_if #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) bus ();

  call_return_stack #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [ADDR_W-1:0] model_q[$];  // front = top of stack
  logic [ADDR_W-1:0] exp_q[$];    // values a pop must show in its own cycle
  logic m_ovf;
  logic m_unf;
  logic pop_pending;

  // Drive one cycle's inputs and advance the model as the next edge will.
  task automatic drive(input logic p, input logic q, input logic [ADDR_W-1:0] d, input logic f);
    bus.PUSH = p; bus.POP = q; bus.PUSH_DATA = d; bus.FLUSH = f;
    pop_pending = 1'b0;
    if (rst) begin
      model_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (f) begin
      model_q.delete();
    end else if (p && !q) begin
      if (model_q.size() < DEPTH) model_q.push_front(d);
      else m_ovf = 1'b1;
    end else if (!p && q) begin
      if (model_q.size() > 0) begin
        exp_q.push_back(model_q[0]); pop_pending = 1'b1; void'(model_q.pop_front());
      end else m_unf = 1'b1;
    end else if (p && q) begin
      if (model_q.size() > 0) begin
        exp_q.push_back(model_q[0]); pop_pending = 1'b1; model_q[0] = d;
      end else begin
        model_q.push_front(d); m_unf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    bus.PUSH = 1'b0; bus.POP = 1'b0; bus.FLUSH = 1'b0; bus.PUSH_DATA = '0;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] got;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    vectors++;
    if (bus.COUNT !== 6'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", bus.COUNT); end
    vectors++;
    if (bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0) begin miscompares++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", bus.EMPTY, bus.FULL); end
    vectors++;
    if (bus.OVF !== 1'b0 || bus.UNF !== 1'b0) begin miscompares++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", bus.OVF, bus.UNF); end
    // single push then pop
    drive(1'b1, 1'b0, 10'h155, 1'b0); tick();
    vectors++;
    if (bus.STACK_OUT !== 10'h155 || bus.COUNT !== 6'd1 || bus.EMPTY !== 1'b0) begin
      miscompares++; $display("FAIL push1 got out=%h cnt=%0d empty=%b exp 155 1 0", bus.STACK_OUT, bus.COUNT, bus.EMPTY);
    end
    vectors++;
    if (dut.sp !== 5'd31) begin miscompares++; $display("FAIL push1_sp got %0d exp 31", dut.sp); end
    drive(1'b0, 1'b1, '0, 1'b0);
    vectors++;
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h000;
    if (bus.STACK_OUT !== got || got !== 10'h155) begin miscompares++; $display("FAIL pop1 got %h exp 155", bus.STACK_OUT); end
    tick();
    vectors++;
    if (bus.COUNT !== 6'd0 || bus.EMPTY !== 1'b1) begin miscompares++; $display("FAIL pop1_after got cnt=%0d empty=%b exp 0 1", bus.COUNT, bus.EMPTY); end
  endtask

  task automatic test_lifo();
    logic [ADDR_W-1:0] got;
    for (int i = 1; i <= 3; i++) begin drive(1'b1, 1'b0, ADDR_W'(i), 1'b0); tick(); end
    for (int i = 3; i >= 1; i--) begin
      drive(1'b0, 1'b1, '0, 1'b0);
      vectors++;
      if (!pop_pending) begin miscompares++; $display("FAIL lifo_pop%0d got no_entry exp %h", i, ADDR_W'(i)); end
      else begin
        got = exp_q.pop_front();
        if (bus.STACK_OUT !== got || got !== ADDR_W'(i)) begin miscompares++; $display("FAIL lifo_pop%0d got %h exp %h", i, bus.STACK_OUT, ADDR_W'(i)); end
      end
      tick();
    end
    vectors++;
    if (bus.EMPTY !== 1'b1 || bus.OVF !== 1'b0 || bus.UNF !== 1'b0) begin
      miscompares++; $display("FAIL lifo_end got empty=%b ovf=%b unf=%b exp 1 0 0", bus.EMPTY, bus.OVF, bus.UNF);
    end
  endtask

  task automatic test_full_ovf();
    logic [ADDR_W-1:0] got;
    for (int i = 0; i < 32; i++) begin drive(1'b1, 1'b0, ADDR_W'(10'h100 + i), 1'b0); tick(); end
    vectors++;
    if (bus.FULL !== 1'b1 || bus.COUNT !== 6'd32) begin miscompares++; $display("FAIL full got full=%b cnt=%0d exp 1 32", bus.FULL, bus.COUNT); end
    vectors++;
    if (dut.sp !== 5'd0 || dut.mem[0] !== 10'h11F) begin miscompares++; $display("FAIL wrap got sp=%0d mem0=%h exp 0 11f", dut.sp, dut.mem[0]); end
    drive(1'b1, 1'b0, 10'h3FF, 1'b0); tick();
    vectors++;
    if (bus.OVF !== 1'b1 || bus.COUNT !== 6'd32 || bus.STACK_OUT !== 10'h11F) begin
      miscompares++; $display("FAIL ovf got ovf=%b cnt=%0d out=%h exp 1 32 11f", bus.OVF, bus.COUNT, bus.STACK_OUT);
    end
    got = '0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, '0, 1'b0);
      vectors++;
      if (!pop_pending) begin miscompares++; $display("FAIL drain%0d got no_entry exp entry", i); end
      else begin
        got = exp_q.pop_front();
        if (bus.STACK_OUT !== got) begin miscompares++; $display("FAIL drain%0d got %h exp %h", i, bus.STACK_OUT, got); end
      end
      tick();
    end
    vectors++;
    if (got !== 10'h100 || bus.EMPTY !== 1'b1) begin miscompares++; $display("FAIL drain_end got last=%h empty=%b exp 100 1", got, bus.EMPTY); end
  endtask

  task automatic test_underflow();
    logic [ADDR_W-1:0] got;
    drive(1'b0, 1'b1, '0, 1'b0); tick();
    vectors++;
    if (bus.UNF !== 1'b1 || bus.COUNT !== 6'd0) begin miscompares++; $display("FAIL unf got unf=%b cnt=%0d exp 1 0", bus.UNF, bus.COUNT); end
    drive(1'b1, 1'b1, 10'h0AA, 1'b0); tick();
    vectors++;
    if (bus.COUNT !== 6'd1 || bus.STACK_OUT !== 10'h0AA || bus.UNF !== 1'b1) begin
      miscompares++; $display("FAIL pushpop_empty got cnt=%0d out=%h unf=%b exp 1 0aa 1", bus.COUNT, bus.STACK_OUT, bus.UNF);
    end
    drive(1'b0, 1'b1, '0, 1'b0);
    vectors++;
    got = pop_pending ? exp_q.pop_front() : 10'h000;
    if (bus.STACK_OUT !== got || got !== 10'h0AA) begin miscompares++; $display("FAIL unf_drain got %h exp 0aa", bus.STACK_OUT); end
    tick();
  endtask

  task automatic test_replace();
    logic [ADDR_W-1:0] got;
    drive(1'b1, 1'b0, 10'h010, 1'b0); tick();
    drive(1'b1, 1'b0, 10'h020, 1'b0); tick();
    drive(1'b1, 1'b1, 10'h030, 1'b0);
    vectors++;
    got = pop_pending ? exp_q.pop_front() : 10'h000;
    if (bus.STACK_OUT !== got || got !== 10'h020) begin miscompares++; $display("FAIL replace_same got %h exp 020", bus.STACK_OUT); end
    tick();
    vectors++;
    if (bus.STACK_OUT !== 10'h030 || bus.COUNT !== 6'd2) begin miscompares++; $display("FAIL replace_after got out=%h cnt=%0d exp 030 2", bus.STACK_OUT, bus.COUNT); end
    drive(1'b0, 1'b1, '0, 1'b0);
    vectors++;
    got = pop_pending ? exp_q.pop_front() : 10'h000;
    if (bus.STACK_OUT !== got || got !== 10'h030) begin miscompares++; $display("FAIL replace_pop1 got %h exp 030", bus.STACK_OUT); end
    tick();
    drive(1'b0, 1'b1, '0, 1'b0);
    vectors++;
    got = pop_pending ? exp_q.pop_front() : 10'h000;
    if (bus.STACK_OUT !== got || got !== 10'h010) begin miscompares++; $display("FAIL replace_pop2 got %h exp 010", bus.STACK_OUT); end
    tick();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, ADDR_W'(10'h200 + i), 1'b0); tick(); end
    vectors++;
    if (bus.COUNT !== 6'd5 || bus.OVF !== 1'b1) begin miscompares++; $display("FAIL pre_flush got cnt=%0d ovf=%b exp 5 1", bus.COUNT, bus.OVF); end
    drive(1'b1, 1'b1, 10'h155, 1'b1); tick();
    vectors++;
    if (bus.COUNT !== 6'd0 || bus.EMPTY !== 1'b1 || bus.OVF !== 1'b1 || bus.UNF !== m_unf) begin
      miscompares++; $display("FAIL flush got cnt=%0d empty=%b ovf=%b unf=%b exp 0 1 1 %b", bus.COUNT, bus.EMPTY, bus.OVF, bus.UNF, m_unf);
    end
    vectors++;
    if (dut.mem[31] !== 10'h200) begin miscompares++; $display("FAIL flush_nowrite got %h exp 200", dut.mem[31]); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 10'h2AB, 1'b0); tick();
    rst = 1'b0;
    vectors++;
    if (bus.COUNT !== 6'd0 || bus.OVF !== 1'b0 || bus.UNF !== 1'b0 || dut.sp !== 5'd0) begin
      miscompares++; $display("FAIL rst_push got cnt=%0d ovf=%b unf=%b sp=%0d exp 0 0 0 0", bus.COUNT, bus.OVF, bus.UNF, dut.sp);
    end
    vectors++;
    if (dut.mem[31] !== 10'h200) begin miscompares++; $display("FAIL rst_nowrite got %h exp 200", dut.mem[31]); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] got;
    int unsigned r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(99);
      if (r < 40)      drive(1'b1, 1'b0, ADDR_W'($urandom), 1'b0);
      else if (r < 72) drive(1'b0, 1'b1, '0, 1'b0);
      else if (r < 92) drive(1'b1, 1'b1, ADDR_W'($urandom), 1'b0);
      else if (r < 95) drive(1'b1, 1'b0, ADDR_W'($urandom), 1'b1);
      else             drive(1'b0, 1'b0, ADDR_W'($urandom), 1'b0);
      if (pop_pending) begin
        got = exp_q.pop_front();
        vectors++;
        if (bus.STACK_OUT !== got) begin miscompares++; $display("FAIL b2b_pop%0d got %h exp %h", n, bus.STACK_OUT, got); end
      end
      tick();
      vectors++;
      if (bus.COUNT !== 6'(model_q.size()) || bus.EMPTY !== (model_q.size() == 0) ||
          bus.FULL !== (model_q.size() == DEPTH) || bus.OVF !== m_ovf || bus.UNF !== m_unf) begin
        miscompares++;
        $display("FAIL b2b_state%0d got cnt=%0d e=%b f=%b o=%b u=%b exp cnt=%0d o=%b u=%b",
                 n, bus.COUNT, bus.EMPTY, bus.FULL, bus.OVF, bus.UNF, model_q.size(), m_ovf, m_unf);
      end
      if (model_q.size() > 0) begin
        vectors++;
        if (bus.STACK_OUT !== model_q[0]) begin miscompares++; $display("FAIL b2b_top%0d got %h exp %h", n, bus.STACK_OUT, model_q[0]); end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_ovf = 1'b0; m_unf = 1'b0; pop_pending = 1'b0;
    rst = 1'b1;
    bus.PUSH = 1'b0; bus.POP = 1'b0; bus.FLUSH = 1'b0; bus.PUSH_DATA = '0;
    @(negedge clk);
    test_reset();
    test_lifo();
    test_full_ovf();
    test_underflow();
    test_replace();
    test_flush_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
